// File: rtl/uart_pkt_tx.sv
// rtl/uart_pkt_tx.sv - packet framer and 8N1 UART serializer
//
// Sends one frame per accepted start: PREFIX, addr, len, len payload bytes
// popped from a show-ahead FIFO, then the XOR of addr, len and the payload.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   start, addr, len    frame request and descriptor (sampled while idle)
//   fifo_q, fifo_empty  show-ahead payload FIFO head and empty flag
//   fifo_rdreq          one-cycle pop of fifo_q
//   tx                  UART line, idle high
//   busy, done          frame in progress, one-cycle completion pulse

module uart_pkt_tx #(
  parameter int         CLK_HZ   = 48_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] PREFIX   = 8'hDD,
  parameter int         GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_T    = CLK_HZ / BAUD;
  localparam int LAST_BIT = 9 + GAP_BITS;   // stop bit plus gap bits
  localparam int CW       = (BIT_T > 1) ? $clog2(BIT_T) : 1;
  localparam int IW       = $clog2(LAST_BIT + 1);

  localparam logic [CW-1:0] BIT_END      = CW'(BIT_T - 1);
  localparam logic [IW-1:0] IDX_END      = IW'(LAST_BIT);
  localparam logic [IW-1:0] IDX_DATA_END = IW'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX, S_ADDR, S_LEN, S_PAYLOAD, S_CRC
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic [IW-1:0] bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_q, tx_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    byte_cnt, byte_cnt_d;   // payload bytes not yet fetched
  logic [7:0]    csum, csum_d;
  logic          waiting, waiting_d;     // payload underflow, line held idle
  logic          done_q, done_d;

  logic          bit_end, byte_end;
  logic          load, fetch;
  logic [7:0]    load_val;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= 8'h00;
      tx_q     <= 1'b1;
      addr_q   <= 8'h00;
      len_q    <= 8'h00;
      byte_cnt <= 8'h00;
      csum     <= 8'h00;
      waiting  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      byte_cnt <= byte_cnt_d;
      csum     <= csum_d;
      waiting  <= waiting_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    tx_d       = tx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt;
    csum_d     = csum;
    waiting_d  = waiting;
    done_d     = 1'b0;
    fifo_rdreq = 1'b0;
    load       = 1'b0;
    load_val   = 8'h00;
    fetch      = 1'b0;
    bit_end    = (bit_cnt == BIT_END);
    byte_end   = bit_end && (bit_idx == IDX_END);

    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        // done_q blocks a start held through the completion cycle
        if (start && !done_q) begin
          addr_d     = addr;
          len_d      = len;
          byte_cnt_d = len;
          csum_d     = addr ^ len;
          state_d    = S_PREFIX;
          load       = 1'b1;
          load_val   = PREFIX;
        end
      end
      default: begin
        if (waiting) begin
          fetch = 1'b1;
        end else if (!bit_end) begin
          bit_cnt_d = bit_cnt + 1'b1;
        end else if (!byte_end) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx_d <= IDX_DATA_END) begin
            tx_d    = shreg[0];
            shreg_d = {1'b0, shreg[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end else begin
          // Byte boundary: the next byte starts on this same edge
          case (state)
            S_PREFIX: begin
              state_d  = S_ADDR;
              load     = 1'b1;
              load_val = addr_q;
            end
            S_ADDR: begin
              state_d  = S_LEN;
              load     = 1'b1;
              load_val = len_q;
            end
            S_LEN: begin
              if (len_q == 8'h00) begin
                state_d  = S_CRC;
                load     = 1'b1;
                load_val = csum;
              end else begin
                state_d = S_PAYLOAD;
                fetch   = 1'b1;
              end
            end
            S_PAYLOAD: begin
              if (byte_cnt == 8'h00) begin
                state_d  = S_CRC;
                load     = 1'b1;
                load_val = csum;
              end else begin
                fetch = 1'b1;
              end
            end
            S_CRC: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              tx_d    = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    if (fetch) begin
      if (!fifo_empty) begin
        fifo_rdreq = 1'b1;
        load       = 1'b1;
        load_val   = fifo_q;
        csum_d     = csum ^ fifo_q;
        byte_cnt_d = byte_cnt - 8'd1;
        waiting_d  = 1'b0;
      end else begin
        waiting_d = 1'b1;
        tx_d      = 1'b1;
      end
    end

    // Every byte start reloads the bit timer, so bytes never drift
    if (load) begin
      shreg_d   = load_val;
      tx_d      = 1'b0;
      bit_cnt_d = '0;
      bit_idx_d = '0;
    end
  end

  assign tx   = tx_q;
  assign busy = (state != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb/tb_uart_pkt_tx.sv - directed self-checking bench for uart_pkt_tx

module tb_uart_pkt_tx;

  // 1_000_000 / 93_000 = 10.75 truncates to 10 clocks per bit; GAP_BITS=1
  localparam int BT     = 10;
  localparam int BYTE_T = 110;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic [7:0] addr;
  logic [7:0] len;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic       tx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int bad_pops = 0;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int rx_base = 0;

  int t0;
  int p0;
  int dseen;
  int bseen;

  uart_pkt_tx #(
    .CLK_HZ  (1_000_000),
    .BAUD    (93_000),
    .PREFIX  (8'hDD),
    .GAP_BITS(1)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .fifo_q    (fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_q     = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rdreq) begin
      pops <= pops + 1;
      if (fifo_empty) bad_pops <= bad_pops + 1;
      else            rd_ptr   <= rd_ptr + 1;
    end
  end

  // UART receiver: mid-bit sampling at BT clocks per bit
  initial begin : rx_mon
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
        repeat (4) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BT) @(negedge clk);
            b[i] = tx;
          end
          repeat (BT) @(negedge clk);
          rx_q.push_back(b);
        end
      end
      prev = tx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] l, output int ts);
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    ts    = cyc;
    chk("start_busy", busy, 1);
    chk("start_tx_low", tx, 0);
  endtask

  task automatic wait_done(input int ts, input int exp_t, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cyc - ts, exp_t);
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, rx_q.size() - rx_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_base + i < rx_q.size())
        chk($sformatf("%s_b%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
    end
  endtask

  task automatic chk_idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    addr  = 8'h00;
    len   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdreq", fifo_rdreq, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: addr 14, two payload bytes
    push(8'h16);
    push(8'h1D);
    p0      = pops;
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h14, 8'h02, 8'h16, 8'h1D, 8'h1D};
    do_start(8'h14, 8'h02, t0);
    wait_done(t0, 6 * BYTE_T, "t1_frame_time");
    chk("t1_pops", pops - p0, 2);
    chk_bytes("t1");
    chk_idle_after("t1");

    // Frame 2: len 0, a stray FIFO byte must not be popped
    push(8'hEE);
    p0      = pops;
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h15, 8'h00, 8'h15};
    do_start(8'h15, 8'h00, t0);
    wait_done(t0, 4 * BYTE_T, "t2_frame_time");
    chk("t2_pops", pops - p0, 0);
    chk_bytes("t2");
    chk_idle_after("t2");
    wr_ptr = rd_ptr;

    // Frame 3: 64 payload bytes 1..64
    for (int i = 1; i <= 64; i++) push(8'(i));
    p0      = pops;
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h16, 8'h40};
    for (int i = 1; i <= 64; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h16);
    do_start(8'h16, 8'h40, t0);
    wait_done(t0, 68 * BYTE_T, "t3_frame_time");
    chk("t3_pops", pops - p0, 64);
    chk("t3_fifo_empty", fifo_empty, 1);
    chk_bytes("t3");
    chk_idle_after("t3");

    // Frame 4: second payload byte arrives late
    push(8'hA5);
    p0      = pops;
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h20, 8'h02, 8'hA5, 8'h3C, 8'hBB};
    do_start(8'h20, 8'h02, t0);
    while (cyc < t0 + 600) @(negedge clk);
    chk("t4_underflow_tx_high", tx, 1);
    chk("t4_underflow_busy", busy, 1);
    chk("t4_underflow_pops", pops - p0, 1);
    while (cyc < t0 + 700) @(negedge clk);
    push(8'h3C);
    wait_done(t0, 921, "t4_frame_time");
    chk("t4_pops", pops - p0, 2);
    chk_bytes("t4");
    chk_idle_after("t4");

    // Frame 5: starts while busy are ignored; start in done cycle ignored,
    // start one cycle later accepted
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h30, 8'h00, 8'h30};
    do_start(8'h30, 8'h00, t0);
    for (int k = 0; k < 3; k++) begin
      repeat (60) @(negedge clk);
      start = 1'b1;
      addr  = 8'h99;
      len   = 8'h05;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(t0, 4 * BYTE_T, "t5a_frame_time");
    chk_bytes("t5a");
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h31, 8'h00, 8'h31};
    start = 1'b1;
    addr  = 8'h31;
    len   = 8'h00;
    @(posedge clk);
    #1;
    chk("t5_start_in_done_ignored", busy, 0);
    @(posedge clk);
    #1;
    chk("t5_start_after_done_busy", busy, 1);
    chk("t5_start_after_done_tx", tx, 0);
    t0    = cyc;
    start = 1'b0;
    wait_done(t0, 4 * BYTE_T, "t5b_frame_time");
    chk_bytes("t5b");
    chk_idle_after("t5b");

    // Frame 6: reset during the ADDR byte, then a clean frame
    push(8'h77);
    do_start(8'h40, 8'h01, t0);
    while (cyc < t0 + 150) @(negedge clk);
    chk("t6_addr_bit3_low", tx, 0);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    dseen = 0;
    bseen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) dseen++;
      if (busy === 1'b1) bseen++;
    end
    chk("t6_no_done_after_abort", dseen, 0);
    chk("t6_no_busy_after_abort", bseen, 0);
    p0      = pops;
    rx_base = rx_q.size();
    exp_q   = '{8'hDD, 8'h41, 8'h01, 8'h77, 8'h37};
    do_start(8'h41, 8'h01, t0);
    wait_done(t0, 5 * BYTE_T, "t6_frame_time");
    chk("t6_pops", pops - p0, 1);
    chk_bytes("t6");
    chk_idle_after("t6");

    chk("no_pop_when_empty", bad_pops, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pkt_tx.md
# uart_pkt_tx

Packet framer and UART serializer for the board-to-host link. It takes a message descriptor (destination address and length) plus a payload from a show-ahead FIFO. It emits the frame prefix 0xDD, address, length, payload and an XOR checksum as 8N1 UART bytes on `tx`. It sits between the per-source message FIFOs and the top-level `tx` pin, and is the transmit counterpart of the packet receiver on `rx`.

## Interface
- `CLK_HZ`, 48_000_000, system clock frequency in Hz.
- `BAUD`, 115200, UART bit rate.
- `PREFIX`, 8'hDD, first byte of every frame.
- `GAP_BITS`, 0, extra idle (high) bit times appended after each stop bit.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to send one frame; sampled only while `busy`=0.
- `addr`  in  8  destination address, captured on accepted `start`.
- `len`  in  8  payload byte count (0..255), captured on accepted `start`.
- `fifo_q`  in  8  payload byte from show-ahead FIFO; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  payload FIFO empty.
- `fifo_rdreq`  out  1  one-cycle pop of the current `fifo_q`.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- Bit period BIT_T = CLK_HZ/BAUD cycles, integer truncation; with the defaults this is 416 cycles.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1, then GAP_BITS idle bits. Total (10+GAP_BITS)·BIT_T cycles per byte.
- Frame FSM states: IDLE -> PREFIX -> ADDR -> LEN -> PAYLOAD (skipped if len=0) -> CRC -> IDLE.
- IDLE: `start`=1 captures `addr` and `len`, clears the checksum and enters PREFIX.
- The checksum is an 8-bit XOR of addr, len and every payload byte. The prefix is excluded.
- PAYLOAD: a byte counter counts down from the captured len.
  - At each byte boundary with `fifo_empty`=0: latch `fifo_q` into the shift register, pulse `fifo_rdreq` for that cycle only, and XOR the byte into the checksum.
  - With `fifo_empty`=1 at a boundary: underflow. Hold `tx`=1 with no timeout, then start the byte on the first cycle `fifo_empty`=0.
  - The byte counter reaching 0 after the last stop/gap moves the FSM to CRC.
- CRC: send the accumulated checksum. After its stop and gap bits, return to IDLE.
- `fifo_rdreq` is never asserted outside PAYLOAD, and never more than len times per frame.
- `start` while `busy`=1 is ignored (not queued). `addr` and `len` changes mid-frame have no effect.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `fifo_rdreq`=0; FSM IDLE; all counters and the checksum 0.
- Reset asserted mid-frame forces `tx`=1 immediately (asynchronous) and aborts the frame. No `done` is issued.
- Start latency: `start` high at edge N gives `busy`=1 and `tx`=0 (prefix start bit) from edge N+1.
- Bytes are back-to-back with no idle cycles between the last stop/gap bit and the next start bit, except during underflow.
- `done` pulses for exactly one cycle. In the same cycle `busy` falls, at the edge ending the CRC byte's last stop/gap bit.
  - Frame length without underflow: (4+len)·(10+GAP_BITS)·BIT_T cycles from start acceptance to the `done` edge.
- A new `start` asserted in the `done` cycle is ignored. A `start` asserted one cycle later is accepted.
- Bit-timing counter reloads at each byte start, so no cumulative drift across bytes.

## Test plan
- addr=0x14, len=2, FIFO holds 0x16,0x1D -> `tx` carries bytes DD 14 02 16 1D 1D (crc 0x1D). Each bit is 416 cycles. `fifo_rdreq` pulses exactly twice. `done` arrives 24960 cycles after start.
- addr=0x15, len=0 -> DD 15 00 15 on `tx`. `fifo_rdreq` never asserts. `done` arrives after 16640 cycles.
- addr=0x16, len=64, payload 1..64 -> 68 bytes on `tx`, checksum 0x16, exactly 64 pops, FIFO empty at `done`.
- Underflow: len=2, the second byte arrives 5000 cycles after the first stop bit -> `tx` held high for the gap, then resumes. The sequence and checksum are unchanged and `done` is delayed accordingly.
- `start` pulsed repeatedly while `busy` -> only one frame sent. `start` in the cycle after `done` -> a second frame begins immediately.
- `n_rst` pulled low during the ADDR byte -> `tx`=1, `busy`=0 and no `done`. After release, a new `start` sends a complete correct frame.
